// File: rtl/ipsl_pcie_dma_pkg.sv
// ipsl_pcie_dma_pkg: shared encodings and helpers for the DMA TLP transmit scheduler.
// Rev 1.0
`default_nettype none
package ipsl_pcie_dma_pkg;

  typedef enum logic [1:0] {
    CLS_CPL = 2'd0,
    CLS_P   = 2'd1,
    CLS_NP  = 2'd2,
    CLS_RSV = 2'd3
  } tlp_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } sched_state_e;

  localparam int PD_DW_PER_CDT = 4;
  localparam int PD_SHIFT      = $clog2(PD_DW_PER_CDT);

  // Posted data credits needed for a payload; a length field of 0 means 1024 DW.
  function automatic logic [8:0] pd_need(input logic [9:0] len);
    logic [10:0] sum;
    sum = {1'b0, len} + 11'(PD_DW_PER_CDT - 1);
    if (len == 10'd0) begin
      return 9'd256;
    end
    return 9'(sum >> PD_SHIFT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipsl_pcie_dma_tx_sched_if.sv
// ipsl_pcie_dma_tx_sched_if: request/credit/grant bundle between TLP sources and the scheduler.
// Rev 1.0
`default_nettype none
interface ipsl_pcie_dma_tx_sched_if #(
  parameter int REQ_NUM = 3
);
  logic [REQ_NUM-1:0]    i_req;
  logic [2*REQ_NUM-1:0]  i_req_cls;
  logic [10*REQ_NUM-1:0] i_req_len;
  logic [7:0]            i_xadm_ph_cdts;
  logic [11:0]           i_xadm_pd_cdts;
  logic [7:0]            i_xadm_nph_cdts;
  logic                  i_tlp_done;
  logic [REQ_NUM-1:0]    o_gnt;
  logic                  o_busy;
  logic                  o_cdt_stall;
  logic                  o_proto_err;

  modport master (
    output i_req, i_req_cls, i_req_len, i_xadm_ph_cdts, i_xadm_pd_cdts, i_xadm_nph_cdts,
    output i_tlp_done,
    input  o_gnt, o_busy, o_cdt_stall, o_proto_err
  );

  modport slave (
    input  i_req, i_req_cls, i_req_len, i_xadm_ph_cdts, i_xadm_pd_cdts, i_xadm_nph_cdts,
    input  i_tlp_done,
    output o_gnt, o_busy, o_cdt_stall, o_proto_err
  );
endinterface
`default_nettype wire

// File: rtl/ipsl_pcie_dma_rr_pick.sv
// ipsl_pcie_dma_rr_pick: combinational round-robin picker, search starts just after ptr.
// Rev 1.0
`default_nettype none
module ipsl_pcie_dma_rr_pick
  import ipsl_pcie_dma_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // Walk from the farthest offset down to ptr+1 so the nearest requester overwrites last.
  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    k   = 0;
    for (int off = N; off >= 1; off--) begin
      k = (int'(ptr) + off) % N;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IW'(k);
        vld    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ipsl_pcie_dma_tx_sched.sv
// ipsl_pcie_dma_tx_sched: credit-aware, packet-atomic round-robin grant for the DMA TLP tx mux.
// Rev 1.0
`default_nettype none
module ipsl_pcie_dma_tx_sched
  import ipsl_pcie_dma_pkg::*;
#(
  parameter int REQ_NUM  = 3,
  parameter bit CPL_PRIO = 1'b1,
  parameter int CDT_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  ipsl_pcie_dma_tx_sched_if.slave   bus
);

  localparam int IW = $clog2(REQ_NUM);

  logic [7:0]         ph_q;
  logic [7:0]         nph_q;
  logic [11:0]        pd_q;
  logic [REQ_NUM-1:0] elig_all;
  logic [REQ_NUM-1:0] elig_cpl;

  sched_state_e       state, state_n;
  logic [2:0]         cnt, cnt_n;
  logic [IW-1:0]      rr_ptr, rr_ptr_n;
  logic [REQ_NUM-1:0] gnt_q, gnt_n;
  logic               stall_q, stall_n;
  logic               perr_q, perr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q  <= '0;
      pd_q  <= '0;
      nph_q <= '0;
    end else begin
      ph_q  <= bus.i_xadm_ph_cdts;
      pd_q  <= bus.i_xadm_pd_cdts;
      nph_q <= bus.i_xadm_nph_cdts;
    end
  end

  // Completions carry infinite credit; reserved class is never eligible.
  always_comb begin
    elig_all = '0;
    elig_cpl = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      case (bus.i_req_cls[2*k +: 2])
        CLS_CPL: begin
          elig_all[k] = bus.i_req[k];
          elig_cpl[k] = bus.i_req[k];
        end
        CLS_P:   elig_all[k] = bus.i_req[k] && (ph_q != 8'd0) &&
                               (pd_q >= {3'b000, pd_need(bus.i_req_len[10*k +: 10])});
        CLS_NP:  elig_all[k] = bus.i_req[k] && (nph_q != 8'd0);
        default: elig_all[k] = 1'b0;
      endcase
    end
  end

  logic [REQ_NUM-1:0] cpl_gnt, all_gnt, win_gnt;
  logic [IW-1:0]      cpl_idx, all_idx, win_idx;
  logic               cpl_vld, all_vld, win_vld, use_cpl;

  ipsl_pcie_dma_rr_pick #(.N(REQ_NUM), .IW(IW)) u_pick_cpl (
    .req (elig_cpl),
    .ptr (rr_ptr),
    .gnt (cpl_gnt),
    .idx (cpl_idx),
    .vld (cpl_vld)
  );

  ipsl_pcie_dma_rr_pick #(.N(REQ_NUM), .IW(IW)) u_pick_all (
    .req (elig_all),
    .ptr (rr_ptr),
    .gnt (all_gnt),
    .idx (all_idx),
    .vld (all_vld)
  );

  assign use_cpl = CPL_PRIO && (|elig_cpl);
  assign win_gnt = use_cpl ? cpl_gnt : all_gnt;
  assign win_idx = use_cpl ? cpl_idx : all_idx;
  assign win_vld = use_cpl ? cpl_vld : all_vld;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rr_ptr_n = rr_ptr;
    gnt_n    = gnt_q;
    stall_n  = (state == ST_IDLE) && (|bus.i_req) && !(|elig_all);
    perr_n   = perr_q | (bus.i_tlp_done && (state != ST_GRANT));
    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          gnt_n    = win_gnt;
          rr_ptr_n = win_idx;
          state_n  = ST_GRANT;
        end
      end
      // Request and credit changes are ignored until the TLP's tlast is accepted.
      ST_GRANT: begin
        if (bus.i_tlp_done) begin
          gnt_n   = '0;
          cnt_n   = 3'(CDT_LAT - 1);
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt == 3'd0) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rr_ptr  <= '0;
      gnt_q   <= '0;
      stall_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rr_ptr  <= rr_ptr_n;
      gnt_q   <= gnt_n;
      stall_q <= stall_n;
      perr_q  <= perr_n;
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_cdt_stall = stall_q;
  assign bus.o_proto_err = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_ipsl_pcie_dma_tx_sched.sv
// tb_ipsl_pcie_dma_tx_sched: two schedulers (CPL priority on/off) against a behavioural model.
// Rev 1.0
`default_nettype none
module tb_ipsl_pcie_dma_tx_sched;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [5:0]  cls;
  logic [29:0] len;
  logic [7:0]  ph, nph;
  logic [11:0] pd;
  logic [1:0]  man_done, auto_done, done_w;
  bit          auto_en, spur_en, rnd_dlen, started;
  int          n_chk, n_fail;
  int          gcnt[2];
  int          dlen[2];

  ipsl_pcie_dma_tx_sched_if #(.REQ_NUM(3)) ifa ();
  ipsl_pcie_dma_tx_sched_if #(.REQ_NUM(3)) ifb ();

  assign done_w[0] = auto_en ? auto_done[0] : man_done[0];
  assign done_w[1] = auto_en ? auto_done[1] : man_done[1];

  assign ifa.i_req = req;  assign ifa.i_req_cls = cls;  assign ifa.i_req_len = len;
  assign ifa.i_xadm_ph_cdts = ph;  assign ifa.i_xadm_pd_cdts = pd;
  assign ifa.i_xadm_nph_cdts = nph;  assign ifa.i_tlp_done = done_w[0];
  assign ifb.i_req = req;  assign ifb.i_req_cls = cls;  assign ifb.i_req_len = len;
  assign ifb.i_xadm_ph_cdts = ph;  assign ifb.i_xadm_pd_cdts = pd;
  assign ifb.i_xadm_nph_cdts = nph;  assign ifb.i_tlp_done = done_w[1];

  ipsl_pcie_dma_tx_sched #(.REQ_NUM(3), .CPL_PRIO(1'b1), .CDT_LAT(LAT)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa));
  ipsl_pcie_dma_tx_sched #(.REQ_NUM(3), .CPL_PRIO(1'b0), .CDT_LAT(LAT)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (one per DUT) ----------------
  int          m_mode[2];   // 0 waiting for a decision, 1 TLP granted, 2 credit settle
  int          m_gi[2], m_hold[2], m_ptr[2];
  logic [7:0]  m_ph[2], m_nph[2];
  logic [11:0] m_pd[2];
  bit          m_stall[2], m_perr[2];

  function automatic int cls_of(int k);
    return int'(cls[2*k +: 2]);
  endfunction

  function automatic bit m_elig(int k, logic [7:0] cph, logic [11:0] cpd, logic [7:0] cnph);
    int l, need;
    if (!req[k]) return 1'b0;
    l = int'(len[10*k +: 10]);
    if (l == 0) l = 1024;
    need = (l + 3) / 4;
    case (cls_of(k))
      0:       return 1'b1;
      1:       return (cph != 0) && (int'(cpd) >= need);
      2:       return cnph != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_step(int u);
    bit e[3];
    bit any_e, any_cpl, prio;
    int pick, k;
    if (rst) begin
      m_mode[u] = 0; m_gi[u] = 0; m_hold[u] = 0; m_ptr[u] = 0;
      m_ph[u] = 0; m_pd[u] = 0; m_nph[u] = 0; m_stall[u] = 0; m_perr[u] = 0;
      return;
    end
    prio = (u == 0);
    any_e = 0; any_cpl = 0;
    for (int j = 0; j < 3; j++) begin
      e[j] = m_elig(j, m_ph[u], m_pd[u], m_nph[u]);
      any_e |= e[j];
      if (e[j] && cls_of(j) == 0) any_cpl = 1;
    end
    if (done_w[u] && m_mode[u] != 1) m_perr[u] = 1;
    m_stall[u] = (m_mode[u] == 0) && (req != 0) && !any_e;
    if (m_mode[u] == 0) begin
      pick = -1;
      for (int off = 1; off <= 3; off++) begin
        k = (m_ptr[u] + off) % 3;
        if (pick < 0 && e[k] && (!(prio && any_cpl) || cls_of(k) == 0)) pick = k;
      end
      if (pick >= 0) begin
        m_gi[u] = pick; m_ptr[u] = pick; m_mode[u] = 1;
      end
    end else if (m_mode[u] == 1) begin
      if (done_w[u]) begin
        m_mode[u] = 2; m_hold[u] = LAT;
      end
    end else begin
      m_hold[u]--;
      if (m_hold[u] == 0) m_mode[u] = 0;
    end
    m_ph[u] = ph; m_pd[u] = pd; m_nph[u] = nph;
  endtask

  function automatic logic [2:0] m_gnt(int u);
    return (m_mode[u] == 1) ? 3'(1 << m_gi[u]) : 3'b000;
  endfunction

  function automatic logic [2:0] dgnt(int u);
    return (u == 0) ? ifa.o_gnt : ifb.o_gnt;
  endfunction

  always @(posedge clk) begin
    m_step(0);
    m_step(1);
    started = 1'b1;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("A.gnt",   ifa.o_gnt,       m_gnt(0));
      chk("A.busy",  ifa.o_busy,      m_mode[0] != 0);
      chk("A.stall", ifa.o_cdt_stall, m_stall[0]);
      chk("A.perr",  ifa.o_proto_err, m_perr[0]);
      chk("B.gnt",   ifb.o_gnt,       m_gnt(1));
      chk("B.busy",  ifb.o_busy,      m_mode[1] != 0);
      chk("B.stall", ifb.o_cdt_stall, m_stall[1]);
      chk("B.perr",  ifb.o_proto_err, m_perr[1]);
    end
  end

  // Tlast generator: done after dlen granted cycles, plus rare spurious pulses.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      auto_done[u] = 1'b0;
      if (!auto_en) begin
        gcnt[u] = 0;
      end else if (dgnt(u) != 3'b000) begin
        gcnt[u]++;
        if (gcnt[u] >= dlen[u]) begin
          auto_done[u] = 1'b1;
          gcnt[u] = 0;
          dlen[u] = rnd_dlen ? int'($urandom_range(1, 5)) : 2;
        end
      end else begin
        gcnt[u] = 0;
        if (spur_en && $urandom_range(0, 199) == 0) auto_done[u] = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tfail(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual no grant within bound, required a grant", nm);
  endtask

  task automatic wait_gnt(int u, string nm, output logic [2:0] g, output int lows);
    lows = 0;
    g = 3'b000;
    repeat (40) begin
      cyc(1);
      g = dgnt(u);
      if (g != 3'b000) break;
      lows++;
    end
    if (g == 3'b000) tfail(nm);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; cls = '0; len = '0; ph = '0; pd = '0; nph = '0;
    man_done = '0; auto_en = 0; spur_en = 0; rnd_dlen = 0;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] g;
    logic [2:0] exp3[4];
    logic [2:0] prevg[2];
    int lows, cntc[2];
    n_chk = 0; n_fail = 0; started = 0;
    dlen[0] = 2; dlen[1] = 2;
    man_done = '0; auto_en = 0; spur_en = 0; rnd_dlen = 0;
    ph = '0; pd = '0; nph = '0; len = '0;

    // Reset held with every source requesting completions.
    rst = 1'b1; req = 3'b111; cls = '0;
    repeat (3) begin
      cyc(1);
      chk("T1.gnt", ifa.o_gnt, 3'b000);
      chk("T1.busy", ifa.o_busy, 1'b0);
      chk("T1.perr", ifa.o_proto_err, 1'b0);
    end

    // Credit gate: src2 P 64 DW needs 16 data credits.
    do_reset();
    req = 3'b100; cls = {2'd1, 2'd0, 2'd0}; len = {10'd64, 10'd0, 10'd0};
    ph = 8'd4; pd = 12'd15;
    cyc(4);
    chk("T2.gnt_blocked", ifa.o_gnt, 3'b000);
    chk("T2.stall", ifa.o_cdt_stall, 1'b1);
    pd = 12'd16;
    cyc(1);
    chk("T2.gnt_reg", ifa.o_gnt, 3'b000);
    cyc(1);
    chk("T2.gnt", ifa.o_gnt, 3'b100);
    man_done = 2'b11;
    cyc(1);
    man_done = 2'b00; req = 3'b000;
    chk("T2.gnt_drop", ifa.o_gnt, 3'b000);

    // Round-robin among three NP sources.
    do_reset();
    req = 3'b111; cls = {2'd2, 2'd2, 2'd2}; nph = 8'd8;
    exp3[0] = 3'b010; exp3[1] = 3'b100; exp3[2] = 3'b001; exp3[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(0, "T3.wait", g, lows);
      chk("T3.order", g, exp3[i]);
      if (i > 0) chk("T3.gap", lows + 1, LAT + 1);
      cyc(3);
      man_done = 2'b01;
      cyc(1);
      man_done = 2'b00;
    end

    // CPL priority (A) versus pure round-robin (B).
    do_reset();
    nph = 8'd8;
    cyc(1);
    req = 3'b011; cls = {2'd0, 2'd2, 2'd0};
    auto_en = 1;
    cntc[0] = 0; cntc[1] = 0; prevg[0] = 3'b000; prevg[1] = 3'b000;
    repeat (200) begin
      cyc(1);
      for (int u = 0; u < 2; u++) begin
        g = dgnt(u);
        if (prevg[u] == 3'b000 && g != 3'b000 && cntc[u] < 4) begin
          if (u == 0) chk("T4.prio", g, 3'b001);
          else        chk("T4.rr", g, (cntc[u] % 2 == 0) ? 3'b010 : 3'b001);
          cntc[u]++;
        end
        prevg[u] = g;
      end
      if (cntc[0] >= 4 && cntc[1] >= 4) break;
    end
    if (cntc[0] < 4) tfail("T4.prio_count");
    if (cntc[1] < 4) tfail("T4.rr_count");
    auto_en = 0;

    // Grant held while request and credit vanish.
    do_reset();
    req = 3'b010; cls = {2'd0, 2'd2, 2'd0}; nph = 8'd8;
    wait_gnt(0, "T5.wait", g, lows);
    chk("T5.gnt", g, 3'b010);
    req = 3'b000; nph = 8'd0;
    repeat (5) begin
      cyc(1);
      chk("T5.hold", ifa.o_gnt, 3'b010);
    end
    man_done = 2'b11;
    cyc(1);
    man_done = 2'b00;
    chk("T5.release", ifa.o_gnt, 3'b000);

    // len=0 (1024 DW) needs 256 credits; spurious done is sticky until reset.
    do_reset();
    req = 3'b001; cls = {2'd0, 2'd0, 2'd1}; len = '0; ph = 8'd1; pd = 12'd255;
    cyc(4);
    chk("T6.gnt_255", ifa.o_gnt, 3'b000);
    chk("T6.stall", ifa.o_cdt_stall, 1'b1);
    pd = 12'd256;
    cyc(2);
    chk("T6.gnt_256", ifa.o_gnt, 3'b001);
    man_done = 2'b11;
    cyc(1);
    man_done = 2'b00; req = 3'b000;
    cyc(4);
    chk("T6.perr_clean", ifa.o_proto_err, 1'b0);
    man_done = 2'b11;
    cyc(1);
    man_done = 2'b00;
    chk("T6.perr_set", ifa.o_proto_err, 1'b1);
    cyc(5);
    chk("T6.perr_sticky", ifa.o_proto_err, 1'b1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("T6.perr_rst", ifa.o_proto_err, 1'b0);

    // Randomized traffic checked cycle-by-cycle against the model.
    do_reset();
    auto_en = 1; rnd_dlen = 1; spur_en = 1;
    repeat (4000) begin
      cyc(1);
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 3) == 0) begin
        req = 3'($urandom);
        cls = 6'($urandom);
        for (int k = 0; k < 3; k++)
          len[10*k +: 10] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 3))
                                                        : 10'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        ph  = 8'($urandom_range(0, 2));
        nph = 8'($urandom_range(0, 2));
        pd  = 12'($urandom_range(0, 300));
      end
    end
    rst = 1'b0; auto_en = 0; spur_en = 0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
